sentinel_entropy_health_monitor: RTL
====================================

Name: sentinel_entropy_health_monitor

Overview:
- Sits directly downstream of the ring-oscillator entropy harvester and consumes its SEED_WIDTH-bit raw entropy word and ready flag.
- Runs SP 800-90B-style continuous health tests (Repetition Count Test, Adaptive Proportion Test) bit-serially on each captured word.
- Forwards only passing words to the QRNG conditioner over a valid/ready handshake.
- Raises a sticky alarm after repeated consecutive failures; this is the root-of-trust gate for all seed material.

Parameters:
- SEED_WIDTH, 256: width of the raw entropy word and seed output. Must be a multiple of APT_WINDOW.
- RCT_CUTOFF, 32: run length of identical consecutive bits that fails the RCT. Range 2..SEED_WIDTH.
- APT_WINDOW, 64: APT window length in bits. Windows are aligned to word bit positions.
- APT_CUTOFF, 50: count of window-first-bit occurrences that fails the APT. Range 2..APT_WINDOW.
- ALARM_THRESHOLD, 3: consecutive failed words that latch the alarm. Must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- raw_entropy  in  SEED_WIDTH  raw word from harvester
- raw_valid  in  1  harvester ready (level; may stay high indefinitely)
- seed_out  out  SEED_WIDTH  health-tested seed
- seed_valid  out  1  seed_out is offered
- seed_ready  in  1  consumer accepts seed
- clear_alarm  in  1  single-cycle pulse, exits alarm state
- health_fail  out  1  one-cycle pulse on any word failure
- alarm  out  1  sticky health alarm
- fail_count  out  16  total failed words, saturating at 16'hFFFF
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert by clk domain):
  - state=IDLE.
  - seed_out=0, seed_valid=0, health_fail=0, alarm=0, fail_count=0, busy=0.
  - Internal consecutive-fail counter = 0.
  - Reset mid-scan or mid-offer discards the word; nothing is forwarded.
- States: IDLE, SCAN, OFFER, ALARM.
- IDLE:
  - When raw_valid=1 at a clk edge: capture raw_entropy into the work register, clear the bit index, go to SCAN.
  - When raw_valid=0: stay in IDLE.
- SCAN: one bit per cycle, MSB first (bit SEED_WIDTH-1 down to 0), SEED_WIDTH cycles.
- RCT:
  - The first bit of the word sets run=1.
  - Each following bit equal to the previous bit increments run; a differing bit sets run=1.
  - Fail when run reaches RCT_CUTOFF.
  - Runs never span words.
- APT:
  - The first bit of each window sets ref=bit and cnt=1.
  - Each later bit equal to ref in the same window increments cnt.
  - Fail when cnt reaches APT_CUTOFF.
- Fail (RCT or APT, same cycle counts once):
  - Scan aborts on the failing bit.
  - health_fail pulses high on the next cycle.
  - fail_count increments (saturating); consecutive-fail counter increments (saturating).
  - Next state: ALARM if the consecutive-fail counter reaches ALARM_THRESHOLD, otherwise IDLE.
- Pass (all SEED_WIDTH bits scanned, no fail):
  - seed_out is loaded from the work register.
  - seed_valid=1, consecutive-fail counter cleared, next state OFFER.
  - Latency: capture edge to seed_valid high is SEED_WIDTH+1 edges.
- OFFER:
  - seed_out and seed_valid are held stable until seed_ready=1.
  - Transfer happens on any edge with seed_valid&seed_ready. seed_valid drops on the next cycle and state returns to IDLE.
  - seed_ready asserted before seed_valid has no effect.
  - seed_out retains its last value after transfer.
- IDLE after OFFER or fail: at least one IDLE cycle, so the earliest recapture is 1 edge after return.
- ALARM:
  - alarm=1; no captures; seed_valid=0; raw_valid ignored.
  - clear_alarm=1 sets alarm=0, clears the consecutive-fail counter, and moves to IDLE. fail_count is not cleared.
  - clear_alarm outside ALARM is ignored.
- Simultaneous rst_n low and any input: reset wins.

Test Plan:
- Alternating pattern: raw_entropy={128{2'b10}}, raw_valid=1, seed_ready=1 → seed_valid at capture+257 edges, seed_out equals the pattern, health_fail never pulses, fail_count=0.
- All-zero word → RCT fail at bit 32 (run reaches 32); health_fail pulse at capture+33; fail_count=1; seed_valid never asserts; back in IDLE, busy=0.
- APT only: first 64-bit window contains 50 ones, with no run longer than 8 and no window-external runs → APT fail on the 50th one; remaining windows unscanned; fail_count=1.
- Alarm: three consecutive all-ones words → alarm=1 after the third fail, fail_count=3; raw_valid held high causes no captures; clear_alarm pulse → alarm=0, IDLE, next good word passes; fail_count stays 3.
- Backpressure: good word, seed_ready=0 for 10 cycles after seed_valid → seed_out and seed_valid stable for 10 cycles; seed_ready=1 → transfer, seed_valid=0 next cycle. A fail-then-pass sequence resets the consecutive-fail count (fail, pass, fail, fail gives no alarm).
- Reset mid-scan at bit 100 → all outputs at reset values immediately; after release, a new capture scans from bit SEED_WIDTH-1; the old word is never offered.

Source files
------------

// File: rtl/sentinel_entropy_health_monitor.sv
// sentinel_entropy_health_monitor
//   Root-of-trust gate between the ring-oscillator entropy harvester and the
//   QRNG conditioner. Each captured raw word is scanned one bit per cycle,
//   MSB first. Two continuous health tests run during the scan:
//     - Repetition Count Test (RCT): run of identical consecutive bits.
//     - Adaptive Proportion Test (APT): within each word-aligned window,
//       count of bits equal to the window's first bit.
//   A word that survives the whole scan is offered on a valid/ready
//   handshake. A failing word is dropped and pulses health_fail. Enough
//   consecutive failures latch a sticky alarm that only clear_alarm releases.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   raw_entropy     raw word from harvester
//   raw_valid       harvester word available (level)
//   seed_out        last health-tested word (held after transfer)
//   seed_valid      seed_out offered to consumer
//   seed_ready      consumer accepts seed_out
//   clear_alarm     pulse, leaves ALARM (ignored elsewhere)
//   health_fail     one-cycle pulse per failed word
//   alarm           sticky health alarm
//   fail_count      total failed words, saturating
//   busy            not in IDLE
module sentinel_entropy_health_monitor #(
  parameter int SEED_WIDTH      = 256,
  parameter int RCT_CUTOFF      = 32,
  parameter int APT_WINDOW      = 64,
  parameter int APT_CUTOFF      = 50,
  parameter int ALARM_THRESHOLD = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEED_WIDTH-1:0] raw_entropy,
  input  logic                  raw_valid,
  output logic [SEED_WIDTH-1:0] seed_out,
  output logic                  seed_valid,
  input  logic                  seed_ready,
  input  logic                  clear_alarm,
  output logic                  health_fail,
  output logic                  alarm,
  output logic [15:0]           fail_count,
  output logic                  busy
);

  localparam int CW = $clog2(SEED_WIDTH + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int AW = $clog2(APT_CUTOFF + 1);
  localparam int WW = $clog2(APT_WINDOW);
  localparam int FW = $clog2(ALARM_THRESHOLD + 1);

  typedef enum logic [1:0] {IDLE, SCAN, OFFER, ALARM} state_e;

  state_e                state_q, state_d;
  logic [SEED_WIDTH-1:0] work_q, work_d;
  logic [SEED_WIDTH-1:0] seed_q, seed_d;
  logic                  seed_valid_q, seed_valid_d;
  logic                  health_fail_q, health_fail_d;
  logic                  alarm_q, alarm_d;
  logic [15:0]           fail_count_q, fail_count_d;
  logic [FW-1:0]         consec_q, consec_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic [WW-1:0]         win_q, win_d;
  logic [RW-1:0]         run_q, run_d;
  logic                  prev_q, prev_d;
  logic                  apt_ref_q, apt_ref_d;
  logic [AW-1:0]         apt_cnt_q, apt_cnt_d;

  logic          cur_bit;
  logic          test_fail;
  logic [FW-1:0] consec_inc;

  // The work register rotates left once per scanned bit, so the bit under
  // test is always the MSB and after a full scan it holds the original word.
  assign cur_bit = work_q[SEED_WIDTH-1];

  // Test counters are registered; the verdict on bit k is taken on the edge
  // after bit k was accumulated, which also aborts the scan at that bit.
  assign test_fail = (run_q == RW'(RCT_CUTOFF)) || (apt_cnt_q == AW'(APT_CUTOFF));

  assign consec_inc = (consec_q == FW'(ALARM_THRESHOLD)) ? consec_q : consec_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    seed_d        = seed_q;
    seed_valid_d  = seed_valid_q;
    health_fail_d = 1'b0;
    alarm_d       = alarm_q;
    fail_count_d  = fail_count_q;
    consec_d      = consec_q;
    bitcnt_d      = bitcnt_q;
    win_d         = win_q;
    run_d         = run_q;
    prev_d        = prev_q;
    apt_ref_d     = apt_ref_q;
    apt_cnt_d     = apt_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (raw_valid) begin
          work_d    = raw_entropy;
          bitcnt_d  = '0;
          win_d     = '0;
          run_d     = '0;
          apt_cnt_d = '0;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        if (test_fail) begin
          health_fail_d = 1'b1;
          fail_count_d  = (fail_count_q == 16'hFFFF) ? fail_count_q : fail_count_q + 16'd1;
          consec_d      = consec_inc;
          if (consec_inc >= FW'(ALARM_THRESHOLD)) begin
            alarm_d = 1'b1;
            state_d = ALARM;
          end else begin
            state_d = IDLE;
          end
        end else if (bitcnt_q == CW'(SEED_WIDTH)) begin
          seed_d       = work_q;
          seed_valid_d = 1'b1;
          consec_d     = '0;
          state_d      = OFFER;
        end else begin
          work_d   = {work_q[SEED_WIDTH-2:0], work_q[SEED_WIDTH-1]};
          bitcnt_d = bitcnt_q + 1'b1;
          prev_d   = cur_bit;
          // Runs restart at the first bit of every word.
          run_d    = ((bitcnt_q == '0) || (cur_bit != prev_q)) ? RW'(1) : run_q + 1'b1;
          win_d    = (win_q == WW'(APT_WINDOW - 1)) ? '0 : win_q + 1'b1;
          if (win_q == '0) begin
            apt_ref_d = cur_bit;
            apt_cnt_d = AW'(1);
          end else if (cur_bit == apt_ref_q) begin
            apt_cnt_d = apt_cnt_q + 1'b1;
          end
        end
      end

      OFFER: begin
        if (seed_ready) begin
          seed_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      ALARM: begin
        if (clear_alarm) begin
          alarm_d  = 1'b0;
          consec_d = '0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      work_q        <= '0;
      seed_q        <= '0;
      seed_valid_q  <= 1'b0;
      health_fail_q <= 1'b0;
      alarm_q       <= 1'b0;
      fail_count_q  <= '0;
      consec_q      <= '0;
      bitcnt_q      <= '0;
      win_q         <= '0;
      run_q         <= '0;
      prev_q        <= 1'b0;
      apt_ref_q     <= 1'b0;
      apt_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      seed_q        <= seed_d;
      seed_valid_q  <= seed_valid_d;
      health_fail_q <= health_fail_d;
      alarm_q       <= alarm_d;
      fail_count_q  <= fail_count_d;
      consec_q      <= consec_d;
      bitcnt_q      <= bitcnt_d;
      win_q         <= win_d;
      run_q         <= run_d;
      prev_q        <= prev_d;
      apt_ref_q     <= apt_ref_d;
      apt_cnt_q     <= apt_cnt_d;
    end
  end

  assign seed_out    = seed_q;
  assign seed_valid  = seed_valid_q;
  assign health_fail = health_fail_q;
  assign alarm       = alarm_q;
  assign fail_count  = fail_count_q;
  assign busy        = (state_q != IDLE);

endmodule
